genera_unos: RTL and testbench

//  Inverse of the team's ones-counter datapath.

---
 rtl/genera_unos_pkg.sv | 15 +
 rtl/genera_unos_if.sv | 31 +++
 rtl/genera_unos_uc.sv | 62 ++++++
 rtl/genera_unos.sv | 72 +++++++
 tb/tb_genera_unos.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/genera_unos_pkg.sv
// Shared definitions for the thermometer-code generator: control-unit states and default sizes.
package genera_unos_pkg;

  localparam int unsigned DefNbits = 3;
  localparam int unsigned DefCw    = 4;

  // Encodings are fixed so the states line up with the ones-counter block.
  typedef enum logic [1:0] {
    StInicio   = 2'd0,
    StCarga    = 2'd1,
    StDesplaza = 2'd2,
    StFin      = 2'd3
  } state_e;

endpackage

// File: rtl/genera_unos_if.sv
// start/fin handshake bundle shared with the ones-counter, carrying the request count and result word.
interface genera_unos_if
  import genera_unos_pkg::*;
#(
  parameter int unsigned NBITS = DefNbits,
  parameter int unsigned CW    = DefCw
) ();

  logic             start;
  logic [CW-1:0]    Cuenta;
  logic [NBITS-1:0] Valor;
  logic             fin;
  logic             desborde;

  modport master (
    output start,
    output Cuenta,
    input  Valor,
    input  fin,
    input  desborde
  );

  modport slave (
    input  start,
    input  Cuenta,
    output Valor,
    output fin,
    output desborde
  );

endinterface

// File: rtl/genera_unos_uc.sv
// Control unit for genera_unos: sequences load, shifting and the start/fin handshake.
module genera_unos_uc
  import genera_unos_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic cero,
  output logic CargaC,
  output logic Decrementa,
  output logic LimpiaV,
  output logic DesplazaV,
  output logic fin
);

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StInicio;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    CargaC     = 1'b0;
    Decrementa = 1'b0;
    LimpiaV    = 1'b0;
    DesplazaV  = 1'b0;
    fin        = 1'b0;
    unique case (state_q)
      StInicio: begin
        if (start) begin
          state_d = StCarga;
        end
      end
      StCarga: begin
        CargaC  = 1'b1;
        LimpiaV = 1'b1;
        state_d = StDesplaza;
      end
      StDesplaza: begin
        if (cero) begin
          state_d = StFin;
        end else begin
          Decrementa = 1'b1;
          DesplazaV  = 1'b1;
        end
      end
      StFin: begin
        fin = 1'b1;
        // Holding start keeps us here; a new run needs start to drop first.
        if (!start) begin
          state_d = StInicio;
        end
      end
    endcase
  end

endmodule

// File: rtl/genera_unos.sv
// Builds an NBITS-wide right-justified run of Cuenta ones, one bit per clock, saturating at NBITS.
module genera_unos
  import genera_unos_pkg::*;
#(
  parameter int unsigned NBITS = DefNbits,
  parameter int unsigned CW    = DefCw
) (
  input  logic          clk,
  input  logic          reset,
  genera_unos_if.slave  bus
);

  localparam logic [CW-1:0] NbitsCw = CW'(NBITS);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] valor_q, valor_d;
  logic             desborde_q, desborde_d;

  logic CargaC, Decrementa, LimpiaV, DesplazaV, fin;
  logic cero;
  logic excede;

  assign cero   = (cnt_q == '0);
  assign excede = (bus.Cuenta > NbitsCw);

  genera_unos_uc u_uc (
    .clk        (clk),
    .reset      (reset),
    .start      (bus.start),
    .cero       (cero),
    .CargaC     (CargaC),
    .Decrementa (Decrementa),
    .LimpiaV    (LimpiaV),
    .DesplazaV  (DesplazaV),
    .fin        (fin)
  );

  always_comb begin
    cnt_d      = cnt_q;
    valor_d    = valor_q;
    desborde_d = desborde_q;
    // Clamp keeps the shift count within the word so oversize requests saturate.
    if (CargaC) begin
      cnt_d      = excede ? NbitsCw : bus.Cuenta;
      desborde_d = excede;
    end else if (Decrementa) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (LimpiaV) begin
      valor_d = '0;
    end else if (DesplazaV) begin
      valor_d = (valor_q << 1) | NBITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      valor_q    <= '0;
      desborde_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      valor_q    <= valor_d;
      desborde_q <= desborde_d;
    end
  end

  assign bus.Valor    = valor_q;
  assign bus.fin      = fin;
  assign bus.desborde = desborde_q;

endmodule

// File: tb/tb_genera_unos.sv
// Scoreboard bench for genera_unos: directed runs push expectations, a monitor checks each fin rise.
module tb_genera_unos;
  import genera_unos_pkg::*;

  localparam int unsigned NB = 3;
  localparam int unsigned W  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  genera_unos_if #(.NBITS(NB), .CW(W)) bus ();

  genera_unos #(.NBITS(NB), .CW(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NB-1:0] valor;
    logic          desb;
    int            k;
    int            t0;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic fin_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every rising fin must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset) begin
      fin_prev <= 1'b0;
    end else begin
      if (bus.fin && !fin_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fin", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("valor", 32'(bus.Valor), 32'(mon_e.valor));
          check("desborde", 32'(bus.desborde), 32'(mon_e.desb));
          check("latency", 32'(cyc - mon_e.t0), 32'(mon_e.k + 2));
          check("popcount", 32'($countones(bus.Valor)), 32'(mon_e.k));
        end
      end
      fin_prev <= bus.fin;
    end
  end

  // One run: raise start with Cuenta, optionally drop start / change Cuenta mid-run.
  task automatic run(input logic [W-1:0] c, input logic [NB-1:0] ev, input logic ed,
                     input int k, input bit drop, input bit chg, input bit keep);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.Cuenta = c;
    bus.start  = 1'b1;
    @(negedge clk);
    e.valor = ev;
    e.desb  = ed;
    e.k     = k;
    e.t0    = cyc;
    exp_q.push_back(e);
    if (drop) bus.start = 1'b0;
    @(negedge clk);
    if (chg) bus.Cuenta = ~c;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout_waiting_fin", 32'd0, 32'd1);
      exp_q.delete();
    end
    if (!keep) begin
      bus.start = 1'b0;
      @(negedge clk);
      check("fin_back_to_0", 32'(bus.fin), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.Cuenta = '0;
    #12;
    check("rst_valor", 32'(bus.Valor), 32'd0);
    check("rst_fin", 32'(bus.fin), 32'd0);
    check("rst_desborde", 32'(bus.desborde), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1..3: basic runs, start dropped early, Cuenta changed after load.
    run(4'd3, 3'b111, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    run(4'd0, 3'b000, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    run(4'd2, 3'b011, 1'b0, 2, 1'b0, 1'b1, 1'b0);

    // 4: saturation; desborde and Valor must survive the return to idle.
    run(4'd5, 3'b111, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_desborde_hold", 32'(bus.desborde), 32'd1);
      check("idle_valor_hold", 32'(bus.Valor), 32'd7);
      check("idle_fin", 32'(bus.fin), 32'd0);
    end
    run(4'd1, 3'b001, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    run(4'd15, 3'b111, 1'b1, 3, 1'b0, 1'b0, 1'b0);

    // Async reset while sitting in FIN with desborde set.
    run(4'd4, 3'b111, 1'b1, 3, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rstfin_valor", 32'(bus.Valor), 32'd0);
    check("rstfin_fin", 32'(bus.fin), 32'd0);
    check("rstfin_desborde", 32'(bus.desborde), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b0;

    // 5: async reset mid-shift.
    @(negedge clk);
    bus.Cuenta = 4'd3;
    bus.start  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 check("midshift_valor", 32'(bus.Valor), 32'd3);
    #1 reset = 1'b1;
    #1;
    check("rstmid_valor", 32'(bus.Valor), 32'd0);
    check("rstmid_fin", 32'(bus.fin), 32'd0);
    check("rstmid_desborde", 32'(bus.desborde), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("after_rst_fin", 32'(bus.fin), 32'd0);
    end

    // 6: start held through FIN, then a fresh run.
    run(4'd3, 3'b111, 1'b0, 3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_fin", 32'(bus.fin), 32'd1);
      check("hold_valor", 32'(bus.Valor), 32'd7);
    end
    bus.start = 1'b0;
    run(4'd1, 3'b001, 1'b0, 1, 1'b0, 1'b0, 1'b0);

    // Loopback-style sweep: every k up to NBITS.
    run(4'd0, 3'b000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run(4'd1, 3'b001, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    run(4'd2, 3'b011, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    run(4'd3, 3'b111, 1'b0, 3, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("no_stray_expect", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
